// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: 32-bit loads/stores as two 16-bit phases on an async SRAM.
// Optional out-of-range trap enabled by defining SRAM_CTRL_RANGE_CHK_EN.
module mem_stage_sram_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t             state, state_d;
    logic [3:0]         cnt, cnt_d;
    logic               op_wr, op_wr_d;
    logic [SRAM_AW-2:0] word, word_d;
    logic [15:0]        wdata_hi, wdata_hi_d;
    logic [31:0]        rdata_d;
    logic               err_d;
    logic [SRAM_AW-1:0] sram_addr_d;
    logic [15:0]        sram_wdata_d;
    logic               we_d, oe_d, ce_d;

    logic        req;
    logic        out_of_range;
    logic [31:0] phys;

    assign req  = mem_read | mem_write;
    assign phys = address - BASE_ADDR;

`ifdef SRAM_CTRL_RANGE_CHK_EN
    assign out_of_range = |phys[31:SRAM_AW+1];
    logic unused_phys;
    assign unused_phys = ^phys[1:0];
`else
    // Upper bits are dropped, so out-of-window addresses alias into the SRAM.
    assign out_of_range = 1'b0;
    logic unused_phys;
    assign unused_phys = ^{phys[31:SRAM_AW+1], phys[1:0]};
`endif

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        op_wr_d      = op_wr;
        word_d       = word;
        wdata_hi_d   = wdata_hi;
        rdata_d      = rdata;
        err_d        = err;
        sram_addr_d  = sram_addr;
        sram_wdata_d = sram_wdata;
        we_d         = sram_we_n;
        oe_d         = sram_oe_n;
        ce_d         = sram_ce_n;
        ready        = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    op_wr_d    = mem_write;
                    word_d     = phys[SRAM_AW:2];
                    wdata_hi_d = wdata[31:16];
                    cnt_d      = 4'd0;
                    err_d      = out_of_range;
                    if (out_of_range) begin
                        state_d = DONE;
                    end else begin
                        state_d      = LO;
                        sram_addr_d  = {phys[SRAM_AW:2], 1'b0};
                        sram_wdata_d = wdata[15:0];
                        ce_d         = 1'b0;
                        we_d         = ~mem_write;
                        oe_d         = mem_write;
                    end
                end
            end
            LO: begin
                cnt_d = cnt + 4'd1;
                if (cnt == CNT_LAST) begin
                    cnt_d = 4'd0;
                    if (!op_wr) rdata_d[15:0] = sram_rdata;
                    sram_addr_d  = {word, 1'b1};
                    sram_wdata_d = wdata_hi;
                    state_d      = HI;
                end
            end
            HI: begin
                cnt_d = cnt + 4'd1;
                if (cnt == CNT_LAST) begin
                    cnt_d = 4'd0;
                    if (!op_wr) rdata_d[31:16] = sram_rdata;
                    ce_d    = 1'b1;
                    we_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pipeline advances on this edge, so a held request is not re-accepted here.
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            op_wr      <= 1'b0;
            word       <= '0;
            wdata_hi   <= 16'd0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 16'd0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            op_wr      <= op_wr_d;
            word       <= word_d;
            wdata_hi   <= wdata_hi_d;
            rdata      <= rdata_d;
            err        <= err_d;
            sram_addr  <= sram_addr_d;
            sram_wdata <= sram_wdata_d;
            sram_we_n  <= we_d;
            sram_oe_n  <= oe_d;
            sram_ce_n  <= ce_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: directed cases plus randomized
// load/store traffic against a word-level reference memory.
module tb_mem_stage_sram_ctrl;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          AW   = 18;
`ifdef SRAM_CTRL_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic          clk, rst;
    logic          mem_read, mem_write;
    logic [31:0]   address, wdata, rdata;
    logic          ready, err;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata, sram_rdata;
    logic          sram_we_n, sram_oe_n, sram_ce_n;

    logic          rd1, wr1;
    logic [31:0]   addr1, wd1, rdata1;
    logic          ready1, err1;
    logic [AW-1:0] sram_addr1;
    logic [15:0]   sram_wdata1, sram_rdata1;
    logic          sram_we_n1, sram_oe_n1, sram_ce_n1;

    int tests    = 0;
    int failures = 0;

    mem_stage_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr1),
        .address(addr1), .wdata(wd1), .rdata(rdata1), .ready(ready1), .err(err1),
        .sram_addr(sram_addr1), .sram_wdata(sram_wdata1), .sram_rdata(sram_rdata1),
        .sram_we_n(sram_we_n1), .sram_oe_n(sram_oe_n1), .sram_ce_n(sram_ce_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM device model
    logic [15:0] sram_mem [0:(1<<AW)-1];
    assign sram_rdata  = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;
    assign sram_rdata1 = (!sram_ce_n1 && !sram_oe_n1) ? ~sram_addr1[15:0] : 16'h0000;
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_wdata;

    // Reference model: half-word store keyed by half address
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rdata;
    logic        exp_err;

    function automatic logic [15:0] ref_rd(input int h);
        return ref_mem.exists(h) ? ref_mem[h] : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input bit drop);
        logic [31:0] phys;
        bit          oor, done;
        int          w, exp_low, low, ce_cyc, we_cyc, oe_cyc, bad, overlap, half;
        phys    = a - BASE;
        oor     = RANGE_CHK && (phys >= (32'd1 << (AW + 1)));
        w       = int'((phys >> 2) & ((32'd1 << (AW - 1)) - 1));
        exp_low = oor ? 1 : 2 * W + 1;
        if (!oor) begin
            if (wr) begin
                ref_mem[2*w]   = d[15:0];
                ref_mem[2*w+1] = d[31:16];
            end else begin
                exp_rdata = {ref_rd(2*w+1), ref_rd(2*w)};
            end
        end
        exp_err = oor;
        mem_read = rd; mem_write = wr; address = a; wdata = d;
        low = 0; ce_cyc = 0; we_cyc = 0; oe_cyc = 0; bad = 0; overlap = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1; else low++;
            if (!sram_ce_n) begin
                half = (ce_cyc < W) ? 2*w : 2*w + 1;
                if (sram_addr !== AW'(half)) bad++;
                if (wr && sram_wdata !== ((ce_cyc < W) ? d[15:0] : d[31:16])) bad++;
                ce_cyc++;
            end
            if (!sram_we_n) we_cyc++;
            if (!sram_oe_n) oe_cyc++;
            if (!sram_we_n && !sram_oe_n) overlap++;
            if (drop && i == 1) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        check("done_seen", done, 1);
        check("ready_low", low, exp_low);
        check("ce_cycles", ce_cyc, oor ? 0 : 2 * W);
        check("we_cycles", we_cyc, (!oor && wr) ? 2 * W : 0);
        check("oe_cycles", oe_cyc, (!oor && !wr) ? 2 * W : 0);
        check("phase_addr_data", bad, 0);
        check("overlap", overlap, 0);
        check("rdata", rdata, exp_rdata);
        check("err", err, exp_err);
        @(posedge clk);
        #1;
    endtask

    task automatic access1(input bit wr, input logic [31:0] a, output int low);
        bit done;
        rd1 = ~wr; wr1 = wr; addr1 = a; wd1 = 32'hA5A5_5A5A;
        low = 0; done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ready1) done = 1; else low++;
        end
        check("w1_done", done, 1);
        @(posedge clk);
        #1;
        rd1 = 1'b0; wr1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int low1;
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
        mem_read = 0; mem_write = 0; address = 0; wdata = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
        exp_rdata = 32'd0; exp_err = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        check("rst_rdata", rdata, 0);
        check("rst_err", err, 0);
        check("rst_addr", sram_addr, 0);
        @(posedge clk); #1;

        // Abort a read in the middle of the low phase
        mem_read = 1'b1; address = BASE + 32'd16;
        @(negedge clk);
        @(negedge clk);
        check("lo_oe_active", sram_oe_n, 0);
        #1 rst = 1'b1; mem_read = 1'b0;
        #1;
        check("abort_strobes", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        check("abort_ready", ready, 1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("abort_no_strobe", {sram_ce_n, sram_we_n, sram_oe_n}, 3'b111);
        @(posedge clk); #1;

        access(0, 1, 32'd1032, 32'hDEAD_BEEF, 0);
        idle(1);
        check("store_sram_lo", sram_mem[4], 32'hBEEF);
        check("store_sram_hi", sram_mem[5], 32'hDEAD);
        access(1, 0, 32'd1032, 32'h0, 0);
        idle(2);

        access(0, 1, 32'd1024, 32'h1234_5678, 0);
        access(1, 0, 32'd1024, 32'h0, 0);
        idle(1);

        access(1, 1, BASE + 32'd40, 32'hCAFE_F00D, 0);
        idle(1);
        access(1, 0, BASE + 32'd40, 32'h0, 0);
        idle(1);

        access(1, 0, 32'd1032, 32'h0, 1);
        idle(1);

        access(0, 1, 32'd1020, 32'h0BAD_C0DE, 0);
        idle(1);
        check("err_hold", err, exp_err);
        access(1, 0, 32'd1020, 32'h0, 0);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) a = $urandom();
            else a = BASE + ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            access(op != 1, op != 0, a, $urandom(), 0);
            idle($urandom_range(0, 1));
        end

        access1(1'b1, BASE + 32'd8, low1);
        check("w1_write_low", low1, 3);
        access1(1'b0, BASE + 32'd8, low1);
        check("w1_read_low", low1, 3);
        check("w1_rdata", rdata1, {~16'd5, ~16'd4});

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
